// File: rtl/cpu_mem_pkg.sv
// Shared system constants for the 6502 memory subsystem.
package cpu_mem_pkg;

  localparam int unsigned REG_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned MEM_DEPTH  = 1024;

  localparam logic [ADDR_WIDTH-1:0] INSTRUCTION_BASE = 16'h0200;
  localparam int unsigned           MAX_FW_SIZE      = MEM_DEPTH - 512;

  // Processor status register bit positions.
  localparam int unsigned CARRY = 0;
  localparam int unsigned ZERO  = 1;
  localparam int unsigned NEG   = 7;

endpackage

// File: rtl/cpu_mem.sv
// Byte-wide synchronous system RAM with bulk load and whole-array monitor.
module cpu_mem
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH      = MEM_DEPTH,
  parameter int unsigned ADDR_WIDTH = cpu_mem_pkg::ADDR_WIDTH,
  parameter int unsigned REG_WIDTH  = cpu_mem_pkg::REG_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         we,
  input  logic [REG_WIDTH-1:0]         din,
  input  logic [ADDR_WIDTH-1:0]        addr,
  output logic [REG_WIDTH-1:0]         dout,
  input  logic                         override_mem,
  input  logic [DEPTH*REG_WIDTH-1:0]   mem_override_in,
  output logic [DEPTH*REG_WIDTH-1:0]   mem_monitor
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  // Packed so that location i sits at bits [RW*i +: RW], matching the flat ports.
  logic [DEPTH-1:0][REG_WIDTH-1:0] mem;
  logic [DEPTH-1:0][REG_WIDTH-1:0] img;
  logic                            in_range;
  logic [IDX_W-1:0]                idx;

  assign img         = mem_override_in;
  assign mem_monitor = mem;
  assign in_range    = {1'b0, addr} < DEPTH_A;
  assign idx         = addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (override_mem) begin
      mem  <= img;
      dout <= in_range ? img[idx] : '0;
    end else if (!reset_n) begin
      mem  <= '0;
      dout <= '0;
    end else begin
      if (we && in_range) begin
        mem[idx] <= din;
      end
      dout <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_cpu_mem.sv
module tb_cpu_mem;
  import cpu_mem_pkg::*;

  localparam int unsigned D = MEM_DEPTH;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 we;
  logic [7:0]           din;
  logic [15:0]          addr;
  logic [7:0]           dout;
  logic                 override_mem;
  logic [D*8-1:0]       mem_override_in;
  logic [D*8-1:0]       mem_monitor;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: a plain byte array plus the load image, updated by rule.
  byte unsigned model [D];
  byte unsigned image [D];
  byte unsigned exp_dout;

  cpu_mem #(
    .DEPTH(D),
    .ADDR_WIDTH(16),
    .REG_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .we(we),
    .din(din),
    .addr(addr),
    .dout(dout),
    .override_mem(override_mem),
    .mem_override_in(mem_override_in),
    .mem_monitor(mem_monitor)
  );

  always #5 clk = ~clk;

  task automatic load_image();
    for (int i = 0; i < D; i++) mem_override_in[i*8 +: 8] = image[i];
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
    end
  endtask

  task automatic chk_mon(input string tag);
    logic [D*8-1:0] expv;
    int first;
    for (int i = 0; i < D; i++) expv[i*8 +: 8] = model[i];
    n_assert++;
    assert (mem_monitor === expv)
    else begin
      n_fail++;
      first = 0;
      for (int i = D - 1; i >= 0; i--)
        if (mem_monitor[i*8 +: 8] !== expv[i*8 +: 8]) first = i;
      $error("FAIL %s: mem_monitor byte[%0d] observed %02h expected %02h",
             tag, first, mem_monitor[first*8 +: 8], expv[first*8 +: 8]);
    end
  endtask

  // Apply the current inputs for one edge, advancing the model by rule.
  task automatic edge_step();
    int a;
    a = int'(addr);
    if (override_mem) begin
      exp_dout = (a < D) ? image[a] : 8'h00;
      for (int i = 0; i < D; i++) model[i] = image[i];
    end else if (!reset_n) begin
      exp_dout = 8'h00;
      for (int i = 0; i < D; i++) model[i] = 8'h00;
    end else begin
      exp_dout = (a < D) ? model[a] : 8'h00;
      if (we && a < D) model[a] = din;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag);
    edge_step();
    chk8({tag, "_dout"}, dout, exp_dout);
    chk_mon({tag, "_mon"});
  endtask

  initial begin
    reset_n = 1'b0; we = 1'b1; din = 8'h5A; addr = 16'h0003;
    override_mem = 1'b0;
    for (int i = 0; i < D; i++) image[i] = 8'($urandom);
    load_image();

    // Reset with garbage on the bus.
    edge_step();
    step_chk("reset");
    chk8("reset_dout_zero", dout, 8'h00);

    // Override during reset: image byte i = i[7:0].
    for (int i = 0; i < D; i++) image[i] = 8'(i);
    load_image();
    override_mem = 1'b1; addr = 16'h0000; we = 1'b0;
    step_chk("ovr_in_reset");
    chk8("ovr_byte_0x5", mem_monitor[5*8 +: 8], 8'h05);
    override_mem = 1'b0; reset_n = 1'b1; addr = 16'h0005;
    step_chk("read_after_ovr");
    chk8("read_0x5", dout, 8'h05);

    // Write then read.
    we = 1'b1; addr = 16'h0010; din = 8'hA5;
    step_chk("wr_10");
    chk8("wr_10_mon", mem_monitor[16'h10*8 +: 8], 8'hA5);
    we = 1'b0;
    step_chk("rd_10");
    chk8("rd_10_val", dout, 8'hA5);

    // Read-before-write.
    we = 1'b1; addr = 16'h0020; din = 8'h11;
    step_chk("wr_20a");
    din = 8'h22;
    step_chk("rbw_20");
    chk8("rbw_old", dout, 8'h11);
    we = 1'b0;
    step_chk("rd_20");
    chk8("rd_20_new", dout, 8'h22);

    // Out of range: no write, dout zero.
    we = 1'b1; addr = 16'(D + 3); din = 8'hFF;
    step_chk("oor_wr");
    chk8("oor_dout", dout, 8'h00);
    we = 1'b0; addr = 16'hFFFF;
    step_chk("oor_rd_top");

    // Override beats a simultaneous write.
    for (int i = 0; i < D; i++) image[i] = 8'($urandom);
    image[16'h30] = 8'h3C;
    load_image();
    override_mem = 1'b1; we = 1'b1; addr = 16'h0030; din = 8'h77;
    step_chk("ovr_vs_wr");
    chk8("ovr_30", mem_monitor[16'h30*8 +: 8], 8'h3C);
    override_mem = 1'b0; we = 1'b0;
    step_chk("rd_30");
    chk8("rd_30_val", dout, 8'h3C);

    // Override with out-of-range address yields dout zero.
    override_mem = 1'b1; addr = 16'(D);
    step_chk("ovr_oor");
    override_mem = 1'b0;

    // Random traffic, rare resets and reloads.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset_n      = (r != 0);
      override_mem = (r == 1);
      if (r == 1) begin
        for (int i = 0; i < D; i++) image[i] = 8'($urandom);
        load_image();
      end
      we   = 1'($urandom);
      din  = 8'($urandom);
      addr = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                         : 16'($urandom_range(0, 63));
      step_chk("rand");
    end

    // Reset mid-operation with a write pending clears everything.
    reset_n = 1'b1; override_mem = 1'b0; we = 1'b1; addr = 16'h0007; din = 8'hC3;
    step_chk("pre_rst_wr");
    reset_n = 1'b0; din = 8'h99;
    step_chk("mid_rst");
    chk8("mid_rst_07", mem_monitor[7*8 +: 8], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
